// File: rtl/cpu_dma_engine.sv
// Multi-channel page DMA that halts the CPU and copies 2^LEN_W bytes from a source page
// to a fixed per-channel destination as read/write pairs aligned to get/put cycles.
module cpu_dma_engine #(
  parameter int          NUM_CH      = 2,
  parameter int          LEN_W       = 8,
  parameter logic [15:0] TRIG_BASE   = 16'h4014,
  parameter logic [15:0] DEST_BASE   = 16'h2004,
  parameter logic [15:0] DEST_STRIDE = 16'h0001
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data_out,
  input  logic              cpu_rw,
  output logic              halt,
  output logic              dma_owns_bus,
  output logic [15:0]       bus_addr,
  output logic [7:0]        bus_data_out,
  output logic              bus_rw,
  input  logic [7:0]        bus_data_in,
  output logic [NUM_CH-1:0] busy,
  output logic              done
);

  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LEN_W-1:0] LAST_OFF = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_parity;
  logic [NUM_CH-1:0] r_pending;
  logic [7:0]        r_page [NUM_CH];
  logic [CH_W-1:0]   r_ch;
  logic [LEN_W-1:0]  r_offset;
  logic [7:0]        r_src_page;
  logic [7:0]        r_data;

  logic [NUM_CH-1:0] w_trig;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_take;
  logic [NUM_CH-1:0] w_active;
  logic [CH_W-1:0]   w_sel;
  logic              w_take_en;
  logic              w_owns;
  logic [7:0]        w_sel_page;
  logic [7:0]        w_off8;
  logic [15:0]       w_dest;

  assign w_owns       = (r_state == S_READ) || (r_state == S_WRITE);
  assign dma_owns_bus = w_owns;
  assign w_off8       = 8'(r_offset);
  assign w_dest       = DEST_BASE + 16'(r_ch) * DEST_STRIDE;
  assign w_take_en    = ((r_state == S_IDLE) || (r_state == S_FINISH)) && (|r_pending);

  // cpu_addr is not CPU-driven while the DMA owns the bus, so triggers are masked then
  always_comb begin
    w_trig = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_trig[i] = !cpu_rw && !w_owns && (cpu_addr == TRIG_BASE + 16'(i));
  end

  // Same-cycle trigger writes join the arbitration so a lower channel written a cycle late still wins
  always_comb begin
    w_req = r_pending | w_trig;
    w_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_req[i]) w_sel = CH_W'(i);
  end

  assign w_sel_page = w_trig[w_sel] ? cpu_data_out : r_page[w_sel];

  always_comb begin
    w_take = '0;
    if (w_take_en) w_take[w_sel] = 1'b1;
  end

  always_comb begin
    w_active = '0;
    if ((r_state != S_IDLE) && (r_state != S_FINISH)) w_active[r_ch] = 1'b1;
  end

  assign busy = r_pending | w_active;

  always_comb begin
    w_state_next = r_state;
    halt         = 1'b0;
    bus_rw       = 1'b1;
    bus_addr     = '0;
    bus_data_out = '0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        halt = |r_pending;
        if (|r_pending) w_state_next = S_HALT;
      end
      S_HALT: begin
        halt         = 1'b1;
        w_state_next = r_parity ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        halt         = 1'b1;
        w_state_next = S_READ;
      end
      S_READ: begin
        halt         = 1'b1;
        bus_addr     = {r_src_page, w_off8};
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        halt         = 1'b1;
        bus_rw       = 1'b0;
        bus_addr     = w_dest;
        bus_data_out = r_data;
        w_state_next = (r_offset == LAST_OFF) ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        halt         = 1'b1;
        done         = 1'b1;
        w_state_next = (|r_pending) ? S_HALT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Control state: channel queue, page latches, FSM and get/put parity
  always_ff @(posedge clock) begin
    if (nreset) begin
      r_state   <= S_IDLE;
      r_parity  <= 1'b0;
      r_pending <= '0;
      r_ch      <= '0;
      r_offset  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_page[i] <= '0;
    end else begin
      r_state   <= w_state_next;
      r_parity  <= ~r_parity;
      r_pending <= w_req & ~w_take;
      for (int i = 0; i < NUM_CH; i++)
        if (w_trig[i]) r_page[i] <= cpu_data_out;
      if (w_take_en) begin
        r_ch     <= w_sel;
        r_offset <= '0;
      end else if (r_state == S_WRITE) begin
        r_offset <= r_offset + 1'b1;
      end
    end
  end

  // Datapath: active source page snapshot and the byte carried from READ to WRITE
  always_ff @(posedge clock) begin
    if (w_take_en) r_src_page <= w_sel_page;
    if (r_state == S_READ) r_data <= bus_data_in;
  end

endmodule

// File: tb/tb_cpu_dma_engine.sv
// Directed bench for cpu_dma_engine: a bus scoreboard plus halt/align/done timing checks,
// using a default 2-channel instance and a 4-channel, 16-byte, stride-2 instance.
module tb_cpu_dma_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [15:0] cpu_addr, cpu_addr1;
  logic [7:0]  cpu_dout, cpu_dout1;
  logic        cpu_rw, cpu_rw1;

  logic        halt0, own0, brw0, done0;
  logic [15:0] baddr0;
  logic [7:0]  bdout0, bdin0;
  logic [1:0]  busy0;

  logic        halt1, own1, brw1, done1;
  logic [15:0] baddr1;
  logic [7:0]  bdout1, bdin1;
  logic [3:0]  busy1;

  // Memory image: odd multiplier keeps every byte of a page distinct
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'hA5;
  endfunction

  assign bdin0 = mem_rd(baddr0);
  assign bdin1 = mem_rd(baddr1);

  cpu_dma_engine u_dut0 (
    .clock(clk), .nreset(nreset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_dout),
    .cpu_rw(cpu_rw), .halt(halt0), .dma_owns_bus(own0), .bus_addr(baddr0),
    .bus_data_out(bdout0), .bus_rw(brw0), .bus_data_in(bdin0), .busy(busy0), .done(done0)
  );

  cpu_dma_engine #(.NUM_CH(4), .LEN_W(4), .DEST_STRIDE(16'h0002)) u_dut1 (
    .clock(clk), .nreset(nreset), .cpu_addr(cpu_addr1), .cpu_data_out(cpu_dout1),
    .cpu_rw(cpu_rw1), .halt(halt1), .dma_owns_bus(own1), .bus_addr(baddr1),
    .bus_data_out(bdout1), .bus_rw(brw1), .bus_data_in(bdin1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t exp0[$];
  xfer_t exp1[$];

  int checks = 0;
  int errors = 0;

  // Expected get/put phase: 0 in the first cycle after reset, toggling every clock
  logic par_m = 1'b0;
  always @(posedge clk) par_m <= nreset ? 1'b0 : ~par_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_xfer(input int which, input logic [7:0] page, input logic [15:0] dest,
                           input int len);
    xfer_t t;
    for (int k = 0; k < len; k++) begin
      t.raddr = {page, 8'(k)};
      t.waddr = dest;
      t.data  = mem_rd(t.raddr);
      if (which == 0) exp0.push_back(t);
      else            exp1.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (own0) begin
      checks++;
      assert (exp0.size() != 0) else begin
        errors++;
        $error("FAIL sb0_unexpected: observed bus cycle at %0h, expected none (queue empty)", baddr0);
      end
      if (exp0.size() != 0) begin
        if (brw0) chk("sb0_raddr", 32'(baddr0), 32'(exp0[0].raddr));
        else begin
          chk("sb0_waddr", 32'(baddr0), 32'(exp0[0].waddr));
          chk("sb0_wdata", 32'(bdout0), 32'(exp0[0].data));
          void'(exp0.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (own1) begin
      checks++;
      assert (exp1.size() != 0) else begin
        errors++;
        $error("FAIL sb1_unexpected: observed bus cycle at %0h, expected none (queue empty)", baddr1);
      end
      if (exp1.size() != 0) begin
        if (brw1) chk("sb1_raddr", 32'(baddr1), 32'(exp1[0].raddr));
        else begin
          chk("sb1_waddr", 32'(baddr1), 32'(exp1[0].waddr));
          chk("sb1_wdata", 32'(bdout1), 32'(exp1[0].data));
          void'(exp1.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish by 2000000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_rw = 1'b0;
    tick;
    cpu_rw = 1'b1; cpu_addr = 16'h0000;
  endtask

  initial begin
    int n, n2, drop;
    logic pt;
    nreset = 1'b1;
    cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_dout = 8'h00;
    cpu_rw1 = 1'b1; cpu_addr1 = 16'h0000; cpu_dout1 = 8'h00;
    repeat (3) tick;

    chk("rst_halt", 32'(halt0), 0);
    chk("rst_owns", 32'(own0), 0);
    chk("rst_bus_rw", 32'(brw0), 1);
    chk("rst_bus_addr", 32'(baddr0), 0);
    chk("rst_bus_dout", 32'(bdout0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_busy1", 32'(busy1), 0);
    nreset = 1'b0;
    tick;

    // T1: trigger on a get cycle -> one align cycle
    for (int k = 0; k < 2 && par_m !== 1'b0; k++) tick;
    push_xfer(0, 8'h02, 16'h2004, 256);
    cpu_write(16'h4014, 8'h02);
    chk("t1_halt_next", 32'(halt0), 1);
    chk("t1_owns_halt", 32'(own0), 0);
    chk("t1_busy", 32'(busy0), 1);
    n = 0;
    while (!own0 && n < 10) begin tick; n++; end
    chk("t1_first_read", n, 3);
    n2 = 0;
    while (!done0 && n2 < 600) begin tick; n2++; end
    chk("t1_done_lat", n2, 512);
    chk("t1_busy_at_done", 32'(busy0), 0);
    chk("t1_sb_empty", exp0.size(), 0);
    tick;
    chk("t1_done_pulse", 32'(done0), 0);
    chk("t1_halt_release", 32'(halt0), 0);

    // T2: trigger on a put cycle -> no align; a write during DMA ownership is ignored
    for (int k = 0; k < 2 && par_m !== 1'b1; k++) tick;
    push_xfer(0, 8'h11, 16'h2004, 256);
    cpu_write(16'h4014, 8'h11);
    chk("t2_halt_next", 32'(halt0), 1);
    n = 0;
    while (!own0 && n < 10) begin tick; n++; end
    chk("t2_first_read", n, 2);
    cpu_write(16'h4015, 8'h44);
    n2 = 1;
    while (!done0 && n2 < 600) begin tick; n2++; end
    chk("t2_done_lat", n2, 512);
    chk("t2_busy_at_done", 32'(busy0), 0);
    tick;
    chk("t2_ignored_trig", 32'(halt0), 0);
    chk("t2_sb_empty", exp0.size(), 0);

    // T3: ch1 then ch0 in consecutive cycles -> ch0 first, halt held throughout
    push_xfer(0, 8'h07, 16'h2004, 256);
    push_xfer(0, 8'h03, 16'h2005, 256);
    cpu_write(16'h4015, 8'h03);
    chk("t3_halt", 32'(halt0), 1);
    cpu_write(16'h4014, 8'h07);
    chk("t3_busy_both", 32'(busy0), 3);
    n = 0; drop = 0;
    while (!done0 && n < 600) begin tick; n++; if (!halt0) drop++; end
    chk("t3_busy_mid", 32'(busy0), 2);
    chk("t3_sb_ch1_left", exp0.size(), 256);
    tick;
    n = 0;
    while (!done0 && n < 600) begin tick; n++; if (!halt0) drop++; end
    chk("t3_halt_held", drop, 0);
    chk("t3_busy_end", 32'(busy0), 0);
    chk("t3_sb_empty", exp0.size(), 0);
    tick;

    // T4: reset at pair 100, then a fresh transfer restarts at offset 0
    push_xfer(0, 8'h20, 16'h2004, 256);
    cpu_write(16'h4014, 8'h20);
    n = 0;
    while (!own0 && n < 10) begin tick; n++; end
    repeat (200) tick;
    nreset = 1'b1;
    tick;
    chk("t4_halt", 32'(halt0), 0);
    chk("t4_owns", 32'(own0), 0);
    chk("t4_busy", 32'(busy0), 0);
    chk("t4_done", 32'(done0), 0);
    chk("t4_sb_partial", exp0.size(), 156);
    exp0.delete();
    nreset = 1'b0;
    push_xfer(0, 8'h21, 16'h2004, 256);
    cpu_write(16'h4014, 8'h21);
    n = 0;
    while (!done0 && n < 700) begin tick; n++; end
    chk("t4_restart_done", 32'(done0), 1);
    chk("t4_sb_empty", exp0.size(), 0);
    tick;

    // T5: rewrite the pending channel's page before it starts
    push_xfer(0, 8'h05, 16'h2004, 256);
    cpu_write(16'h4014, 8'h09);
    cpu_write(16'h4014, 8'h05);
    n = 0;
    while (!done0 && n < 700) begin tick; n++; end
    chk("t5_sb_empty", exp0.size(), 0);
    tick;
    chk("t5_no_requeue", 32'(halt0), 0);

    // T6: 4-channel, 16-byte, stride-2 instance, channel 3
    pt = par_m;
    push_xfer(1, 8'h3C, 16'h200A, 16);
    cpu_addr1 = 16'h4017; cpu_dout1 = 8'h3C; cpu_rw1 = 1'b0;
    tick;
    cpu_rw1 = 1'b1; cpu_addr1 = 16'h0000;
    chk("t6_busy3", 32'(busy1), 32'h8);
    chk("t6_halt", 32'(halt1), 1);
    n = 0;
    while (!done1 && n < 100) begin tick; n++; end
    chk("t6_done_lat", n, (pt == 1'b0) ? 35 : 34);
    chk("t6_busy_clear", 32'(busy1), 0);
    chk("t6_sb_empty", exp1.size(), 0);
    tick;
    chk("t6_halt_release", 32'(halt1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
